// File: rtl/gtech_piso_tx.sv
// Parallel-in/serial-out transmitter with a one-word holding register, valid/ready
// handshakes on both the parallel load side and the serial beat side.
module gtech_piso_tx #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [WIDTH-1:0] D,
  input  logic             LOAD_V,
  output logic             LOAD_RDY,
  output logic             SO,
  output logic             SO_V,
  input  logic             SO_RDY,
  output logic             SO_LAST,
  output logic             BUSY
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] hold_q,  hold_d;
  logic             hd_full_q, hd_full_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  logic sh_full_s;
  logic load_xfer_s;
  logic beat_s;
  logic last_beat_s;

  // Move the shift register one place toward the output end, zero-filling the vacated bit.
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] word);
    if (LSB_FIRST) begin
      return {1'b0, word[WIDTH-1:1]};
    end else begin
      return {word[WIDTH-2:0], 1'b0};
    end
  endfunction

  assign sh_full_s   = (state_q == SHIFT);
  assign load_xfer_s = LOAD_V & LOAD_RDY;
  assign beat_s      = sh_full_s & SO_RDY;
  assign last_beat_s = beat_s & (cnt_q == CNT_LAST);

  // Next-state logic: direct load when idle, hold register fill while shifting,
  // and seamless hand-over of the next word on the final beat.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    hold_d    = hold_q;
    hd_full_d = hd_full_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (load_xfer_s) begin
          shreg_d = D;
          cnt_d   = CNT_ZERO;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (last_beat_s) begin
          cnt_d = CNT_ZERO;
          if (hd_full_q) begin
            shreg_d   = hold_q;
            hd_full_d = 1'b0;
          end else if (load_xfer_s) begin
            shreg_d = D;
          end else begin
            shreg_d = shift_one(shreg_q);
            state_d = IDLE;
          end
        end else if (beat_s) begin
          shreg_d = shift_one(shreg_q);
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          shreg_d = shreg_q;
        end
        // A load that is not consumed by the final beat parks in the holding register.
        if (load_xfer_s && !last_beat_s) begin
          hold_d    = D;
          hd_full_d = 1'b1;
        end else begin
          hold_d = hold_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge CP) begin
    if (CD) begin
      state_q   <= IDLE;
      shreg_q   <= {WIDTH{1'b0}};
      hold_q    <= {WIDTH{1'b0}};
      hd_full_q <= 1'b0;
      cnt_q     <= CNT_ZERO;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      hold_q    <= hold_d;
      hd_full_q <= hd_full_d;
      cnt_q     <= cnt_d;
    end
  end

  assign SO       = LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1];
  assign SO_V     = sh_full_s;
  assign SO_LAST  = sh_full_s & (cnt_q == CNT_LAST);
  assign LOAD_RDY = ~hd_full_q & ~CD;
  assign BUSY     = sh_full_s | hd_full_q;

endmodule
